// File: rtl/window_builder.sv
// rtl/window_builder.sv - raster to 3x3 window converter with two line buffers.
// Optional centre-coordinate outputs win_row/win_col under `WINDOW_BUILDER_COORD_EN.
module window_builder #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIX_W-1:0]     pix_in,
    input  logic                 pix_valid,
    input  logic                 pix_sof,
    output logic [9*PIX_W-1:0]   pixelData,
    output logic                 win_valid,
    output logic                 frame_done,
    output logic                 busy
`ifdef WINDOW_BUILDER_COORD_EN
    ,
    output logic [11:0]          win_row,
    output logic [11:0]          win_col
`endif
);

    localparam int AW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [PIX_W-1:0]   lb0_q [IMG_WIDTH];
    logic [PIX_W-1:0]   lb1_q [IMG_WIDTH];

    logic [1:0]         state_q, state_d;
    logic [AW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    // Two most recent columns, each packed {row-2, row-1, row}.
    logic [3*PIX_W-1:0] cm2_q, cm2_d;
    logic [3*PIX_W-1:0] cm1_q, cm1_d;
    logic [9*PIX_W-1:0] pixel_data_q, pixel_data_d;
    logic               win_valid_q, win_valid_d;
    logic               frame_done_q, frame_done_d;
`ifdef WINDOW_BUILDER_COORD_EN
    logic [11:0]        win_row_q, win_row_d;
    logic [11:0]        win_col_q, win_col_d;
`endif

    logic               sof_hit;
    logic [AW-1:0]      eff_col;
    logic [RW-1:0]      eff_row;
    logic               last_col;
    logic               last_row;
    logic [3*PIX_W-1:0] new_col;

    // A start-of-frame pixel is treated as (0,0) regardless of the counters.
    assign sof_hit  = pix_valid && pix_sof;
    assign eff_col  = sof_hit ? '0 : col_q;
    assign eff_row  = sof_hit ? '0 : row_q;
    assign last_col = (eff_col == AW'(IMG_WIDTH - 1));
    assign last_row = (eff_row == RW'(IMG_HEIGHT - 1));
    assign new_col  = {lb1_q[eff_col], lb0_q[eff_col], pix_in};

    always_comb begin
        state_d      = (state_q == ST_DONE) ? ST_FILL : state_q;
        col_d        = col_q;
        row_d        = row_q;
        cm2_d        = cm2_q;
        cm1_d        = cm1_q;
        pixel_data_d = pixel_data_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
`ifdef WINDOW_BUILDER_COORD_EN
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
`endif
        if (pix_valid) begin
            cm2_d = cm1_q;
            cm1_d = new_col;

            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : eff_row + RW'(1);
            end else begin
                col_d = eff_col + AW'(1);
                row_d = eff_row;
            end

            if (sof_hit) begin
                state_d = ST_FILL;
            end
            if (last_col && last_row) begin
                state_d      = ST_DONE;
                frame_done_d = 1'b1;
            end else if (last_col && (eff_row == RW'(1))) begin
                state_d = ST_STREAM;
            end

            // Columns left over from the previous row only sit in the shift
            // window at col 0/1, which this qualifier excludes.
            if ((eff_row >= RW'(2)) && (eff_col >= AW'(2))) begin
                win_valid_d  = 1'b1;
                pixel_data_d = {cm2_q[3*PIX_W-1:2*PIX_W], cm1_q[3*PIX_W-1:2*PIX_W], new_col[3*PIX_W-1:2*PIX_W],
                                cm2_q[2*PIX_W-1:PIX_W],   cm1_q[2*PIX_W-1:PIX_W],   new_col[2*PIX_W-1:PIX_W],
                                cm2_q[PIX_W-1:0],         cm1_q[PIX_W-1:0],         new_col[PIX_W-1:0]};
`ifdef WINDOW_BUILDER_COORD_EN
                win_row_d    = 12'(eff_row) - 12'd1;
                win_col_d    = 12'(eff_col) - 12'd1;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FILL;
            col_q        <= '0;
            row_q        <= '0;
            cm2_q        <= '0;
            cm1_q        <= '0;
            pixel_data_q <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef WINDOW_BUILDER_COORD_EN
            win_row_q    <= '0;
            win_col_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            cm2_q        <= cm2_d;
            cm1_q        <= cm1_d;
            pixel_data_q <= pixel_data_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
`ifdef WINDOW_BUILDER_COORD_EN
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
`endif
        end
    end

    // Line-buffer contents are don't-care after reset; rows 0/1 refill them.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb1_q[eff_col] <= lb0_q[eff_col];
            lb0_q[eff_col] <= pix_in;
        end
    end

    assign pixelData  = pixel_data_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == ST_STREAM);
`ifdef WINDOW_BUILDER_COORD_EN
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
`endif

endmodule

// File: tb/tb_window_builder.sv
// tb/tb_window_builder.sv - randomized and directed bench for window_builder on a 4x4 image.
module tb_window_builder;

    localparam int W = 4;
    localparam int H = 4;
    localparam int P = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic [P-1:0]     pix_in;
    logic             pix_valid;
    logic             pix_sof;
    logic [9*P-1:0]   pixelData;
    logic             win_valid;
    logic             frame_done;
    logic             busy;
`ifdef WINDOW_BUILDER_COORD_EN
    logic [11:0]      win_row;
    logic [11:0]      win_col;
`endif

    window_builder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pixelData  (pixelData),
        .win_valid  (win_valid),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef WINDOW_BUILDER_COORD_EN
        ,
        .win_row    (win_row),
        .win_col    (win_col)
`endif
    );

    always #5 clk = ~clk;

    int             errors = 0;
    int             checks = 0;
    logic [P-1:0]   img [H][W];
    int             m_row;
    int             m_col;
    logic [9*P-1:0] exp_pd;
    int             dut_wins;
    int             dut_fds;
    bit             first_seen;
    logic [P-1:0]   first_ctr;

    task automatic chk(input string tag, input logic [215:0] got, input logic [215:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [P-1:0] pixval(input int r, input int c);
        return {8'(r), 8'(c), 8'(r * 4 + c)};
    endfunction

    // Reference: full-frame image array, windows read straight from it.
    task automatic step(input bit v, input bit s, input logic [P-1:0] px);
        bit ew;
        bit efd;
        int er;
        int ec;
        ew  = 1'b0;
        efd = 1'b0;
        er  = 0;
        ec  = 0;
        rst       = 1'b0;
        pix_valid = v;
        pix_sof   = s;
        pix_in    = px;
        if (v) begin
            if (s) begin
                m_row = 0;
                m_col = 0;
            end
            img[m_row][m_col] = px;
            if (m_row >= 2 && m_col >= 2) begin
                ew     = 1'b1;
                er     = m_row - 1;
                ec     = m_col - 1;
                exp_pd = '0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        exp_pd = {exp_pd[8*P-1:0], img[er+dr][ec+dc]};
            end
            if (m_row == H - 1 && m_col == W - 1) efd = 1'b1;
            m_col++;
            if (m_col == W) begin
                m_col = 0;
                m_row++;
                if (m_row == H) m_row = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("win_valid", win_valid, ew);
        chk("pixelData", pixelData, exp_pd);
        chk("frame_done", frame_done, efd);
        chk("busy", busy, m_row >= 2);
`ifdef WINDOW_BUILDER_COORD_EN
        if (ew) begin
            chk("win_row", win_row, er);
            chk("win_col", win_col, ec);
        end
`endif
        if (win_valid) begin
            dut_wins++;
            if (!first_seen) begin
                first_seen = 1'b1;
                first_ctr  = pixelData[119:96];
            end
        end
        if (frame_done) dut_fds++;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        pix_valid = 1'($urandom % 2);
        pix_sof   = 1'b0;
        pix_in    = 24'($urandom);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        pix_valid = 1'b0;
        m_row     = 0;
        m_col     = 0;
        exp_pd    = '0;
        chk("rst_pixelData", pixelData, 216'd0);
        chk("rst_win_valid", win_valid, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
`ifdef WINDOW_BUILDER_COORD_EN
        chk("rst_win_row", win_row, 12'd0);
        chk("rst_win_col", win_col, 12'd0);
`endif
    endtask

    task automatic clear_counts();
        dut_wins   = 0;
        dut_fds    = 0;
        first_seen = 1'b0;
    endtask

    task automatic send_frame(input bit toggle, input logic [P-1:0] xmask);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                step(1'b1, 1'b0, pixval(r, c) ^ xmask);
                if (toggle) step(1'b0, 1'b0, 24'($urandom));
            end
    endtask

    initial begin
        rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_in = '0;
        m_row = 0; m_col = 0; exp_pd = '0;
        do_reset();

        clear_counts();
        send_frame(1'b0, 24'h0);
        step(1'b0, 1'b0, 24'h0);
        chk("t1_wins", dut_wins, 4);
        chk("t1_fds", dut_fds, 1);
        chk("t1_centre", first_ctr, 24'h010105);

        do_reset();
        clear_counts();
        send_frame(1'b1, 24'h0);
        chk("t2_wins", dut_wins, 4);
        chk("t2_fds", dut_fds, 1);

        do_reset();
        clear_counts();
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 24'hA5A5A5 ^ 24'(i));
        do_reset();
        send_frame(1'b0, 24'h0);
        chk("t3_wins", dut_wins, 4);
        chk("t3_fds", dut_fds, 1);
        chk("t3_centre", first_ctr, 24'h010105);

        clear_counts();
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 24'h5A0000 ^ 24'(i));
        for (int i = 0; i < 16; i++) step(1'b1, i == 0, pixval(i / 4, i % 4));
        step(1'b0, 1'b0, 24'h0);
        chk("t4_wins", dut_wins, 4);
        chk("t4_fds", dut_fds, 1);

        do_reset();
        clear_counts();
        send_frame(1'b0, 24'h0);
        send_frame(1'b0, 24'h800000);
        step(1'b0, 1'b0, 24'h0);
        chk("t5_wins", dut_wins, 8);
        chk("t5_fds", dut_fds, 2);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom % 200 == 0)
                do_reset();
            else
                step(($urandom % 4) != 0, ($urandom % 50) == 0, 24'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
